// File: rtl/proc_pkg.sv
// Shared constants for the simple processor: instruction field positions,
// instruction width and fetch-stage defaults.
package proc_pkg;
   localparam int unsigned INSTR_W      = 32;
   localparam int unsigned FIELD_W      = 5;
   localparam int unsigned OPCODE_MSB   = 31;
   localparam int unsigned OPCODE_LSB   = 27;
   localparam int unsigned SHAMT_MSB    = 11;
   localparam int unsigned SHAMT_LSB    = 7;
   localparam int unsigned DEF_ADDR_W   = 12;
   localparam int unsigned DEF_RESET_PC = 0;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO with flush; head is held in a register so the
// front entry is directly observable and stable until popped.
module fetch_fifo #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [1:0]       count,
   output logic [WIDTH-1:0] head
);
   logic [WIDTH-1:0] tail;

   // Callers never pop when empty nor push when full.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         head  <= '0;
         tail  <= '0;
      end else if (flush) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) head <= push_data;
               else               tail <= push_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  head <= push_data;
               end else begin
                  head <= tail;
                  tail <= push_data;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited imem requests,
// buffers responses for decode and flushes on redirect.
// Defining FETCH_PERF_CNT_EN adds the perf_fetched / perf_flushed counters.
module fetch_unit
   import proc_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned RESET_PC = DEF_RESET_PC
) (
   input  logic               clock,
   input  logic               reset_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_rvalid,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_target,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_flushed,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   output logic [ADDR_W-1:0]  out_pc_plus1,
   output logic [FIELD_W-1:0] out_opcode,
   output logic [FIELD_W-1:0] out_shamt
);
   localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

   logic [ADDR_W-1:0]  pc;
   logic [1:0]         inflight;
   logic [1:0]         discard;
   logic [1:0]         fifo_count;
   logic [ADDR_W-1:0]  tag_pc;
   logic [ENTRY_W-1:0] fifo_head;
   logic [INSTR_W-1:0] head_instr;
   logic [2:0]         credit_used;
   logic               pop;
   logic               push;

   // Credit: outstanding requests plus buffered entries never exceed two.
   assign out_valid   = (fifo_count != 2'd0) && !redirect_valid;
   assign pop         = out_valid && out_ready;
   assign credit_used = 3'(inflight) + 3'(fifo_count) - 3'(pop);
   assign imem_req    = reset_n && !redirect_valid && (credit_used < 3'd2);
   assign imem_addr   = pc;
   assign push        = imem_rvalid && (discard == 2'd0) && !redirect_valid;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)            pc <= ADDR_W'(RESET_PC);
      else if (redirect_valid) pc <= redirect_target;
      else if (imem_req)       pc <= pc + ADDR_W'(1);
   end

   // Every response still owed to the old stream is dropped after a redirect.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                              discard <= '0;
      else if (redirect_valid)                   discard <= inflight - {1'b0, imem_rvalid};
      else if (imem_rvalid && discard != 2'd0)   discard <= discard - 2'd1;
   end

   // In-order address tags; its occupancy is the in-flight request count.
   fetch_fifo #(.WIDTH(ADDR_W)) u_tag_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (imem_req),
      .push_data (pc),
      .pop       (imem_rvalid),
      .flush     (1'b0),
      .count     (inflight),
      .head      (tag_pc)
   );

   fetch_fifo #(.WIDTH(ENTRY_W)) u_out_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (push),
      .push_data ({imem_rdata, tag_pc}),
      .pop       (pop),
      .flush     (redirect_valid),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   assign head_instr   = fifo_head[ENTRY_W-1:ADDR_W];
   assign out_instr    = head_instr;
   assign out_pc       = fifo_head[ADDR_W-1:0];
   assign out_pc_plus1 = out_pc + ADDR_W'(1);
   assign out_opcode   = head_instr[OPCODE_MSB:OPCODE_LSB];
   assign out_shamt    = head_instr[SHAMT_MSB:SHAMT_LSB];

`ifdef FETCH_PERF_CNT_EN
   logic drop;
   assign drop = imem_rvalid && (redirect_valid || discard != 2'd0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         perf_fetched <= '0;
         perf_flushed <= '0;
      end else begin
         if (push) perf_fetched <= perf_fetched + 32'd1;
         perf_flushed <= perf_flushed + 32'(drop) +
                         (redirect_valid ? 32'(fifo_count) : 32'd0);
      end
   end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: in-order memory model with random latency,
// expected PC stream queued on reset/redirect, monitor checks every transfer.
module tb_fetch_unit;
   localparam int unsigned AW  = 12;
   localparam int unsigned RPC = 0;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_rdata;
   logic          imem_rvalid;
   logic          redirect_valid;
   logic [AW-1:0] redirect_target;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_instr;
   logic [AW-1:0] out_pc;
   logic [AW-1:0] out_pc_plus1;
   logic [4:0]    out_opcode;
   logic [4:0]    out_shamt;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]   perf_fetched;
   logic [31:0]   perf_flushed;
`endif

   fetch_unit #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .imem_rvalid     (imem_rvalid),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
`ifdef FETCH_PERF_CNT_EN
      .perf_fetched    (perf_fetched),
      .perf_flushed    (perf_flushed),
`endif
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instr       (out_instr),
      .out_pc          (out_pc),
      .out_pc_plus1    (out_pc_plus1),
      .out_opcode      (out_opcode),
      .out_shamt       (out_shamt)
   );

   always #5 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0] addr;
      int unsigned   due;
   } mreq_t;

   mreq_t         mem_q[$];
   logic [AW-1:0] exp_q[$];
   logic [AW-1:0] exp_tail;
   int unsigned   last_due;
   int unsigned   lat_fix;
   bit            lat_rand;
   logic [31:0]   salt;
   int            tests = 0;
   int            fails = 0;
   int unsigned   req_count = 0;

   function automatic logic [31:0] word(input logic [AW-1:0] a);
      return (32'h1000_0000 + 32'(a)) ^ salt;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected stream: consecutive word addresses from the restart point.
   task automatic restart_model(input logic [AW-1:0] start);
      exp_q.delete();
      exp_tail = start;
   endtask

   // One clock: record last cycle's request, then drive this cycle's inputs.
   task automatic step(input logic rv, input logic [AW-1:0] rt, input logic rdy);
      mreq_t r;
      @(negedge clock);
      if (imem_req) begin
         r.addr = imem_addr;
         r.due  = cyc + (lat_rand ? $urandom_range(1, 4) : lat_fix);
         if (r.due <= last_due) r.due = last_due + 1;
         last_due = r.due;
         mem_q.push_back(r);
      end
      @(posedge clock);
      #1;
      redirect_valid  = rv;
      redirect_target = rt;
      out_ready       = rdy;
      if (rv) restart_model(rt);
      while (exp_q.size() < 16) begin
         exp_q.push_back(exp_tail);
         exp_tail = exp_tail + AW'(1);
      end
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = word(mem_q[0].addr);
         void'(mem_q.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      #1;
   endtask

   // Asynchronous reset pulse; returns inside the first cycle after release.
   task automatic do_reset(input int unsigned hold, input logic rdy, input logic [31:0] new_salt);
      @(posedge clock);
      #1;
      reset_n        = 1'b0;
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      imem_rvalid    = 1'b0;
      mem_q.delete();
      last_due = 0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_out_pc", 32'(out_pc), 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_perf_fetched", perf_fetched, 32'd0);
      chk("rst_perf_flushed", perf_flushed, 32'd0);
`endif
      salt = new_salt;
      repeat (hold) @(posedge clock);
      #1;
      reset_n   = 1'b1;
      out_ready = rdy;
      restart_model(AW'(RPC));
      while (exp_q.size() < 16) begin
         exp_q.push_back(exp_tail);
         exp_tail = exp_tail + AW'(1);
      end
      #1;
      chk("first_req", 32'(imem_req), 32'd1);
      chk("first_addr", 32'(imem_addr), RPC);
   endtask

   // Monitor: request addresses, credit bound, head stability and scoreboard.
   initial begin
      logic [AW-1:0] req_next;
      logic [AW-1:0] e;
      logic [AW-1:0] e_plus1;
      logic [AW-1:0] prev_pc;
      logic [31:0]   w;
      logic [31:0]   prev_instr;
      bit            prev_valid;
      bit            prev_ready;
      int            out_n;
      req_next = AW'(RPC);
      prev_valid = 0; prev_ready = 0; prev_pc = '0; prev_instr = '0; out_n = 0;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            chk("rst_mon_req", 32'(imem_req), 32'd0);
            chk("rst_mon_valid", 32'(out_valid), 32'd0);
            req_next   = AW'(RPC);
            prev_valid = 0;
            out_n      = 0;
         end else begin
            if (redirect_valid) chk("redirect_no_req", 32'(imem_req), 32'd0);
            if (redirect_valid) chk("redirect_no_valid", 32'(out_valid), 32'd0);
            if (imem_req) begin
               chk("req_addr", 32'(imem_addr), 32'(req_next));
               req_next = req_next + AW'(1);
               req_count++;
            end
            if (redirect_valid) req_next = redirect_target;
            out_n = out_n + int'(imem_req) - int'(imem_rvalid);
            if (out_n > 2) chk("inflight_bound", 32'(out_n), 32'd2);
            if (out_valid) begin
               if (prev_valid && !prev_ready) begin
                  chk("hold_pc", 32'(out_pc), 32'(prev_pc));
                  chk("hold_instr", out_instr, prev_instr);
               end
               if (exp_q.size() == 0) begin
                  chk("unexpected_out_pc", 32'(out_pc), 32'hFFFF_FFFF);
               end else begin
                  e       = exp_q[0];
                  w       = word(e);
                  e_plus1 = e + AW'(1);
                  chk("out_pc", 32'(out_pc), 32'(e));
                  chk("out_instr", out_instr, w);
                  chk("out_opcode", 32'(out_opcode), w >> 27);
                  chk("out_shamt", 32'(out_shamt), (w >> 7) & 32'h1F);
                  chk("out_pc_plus1", 32'(out_pc_plus1), 32'(e_plus1));
                  if (out_ready) void'(exp_q.pop_front());
               end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_pc    = out_pc;
            prev_instr = out_instr;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          seen;
      int unsigned base;
      reset_n = 1'b0; redirect_valid = 1'b0; redirect_target = '0; out_ready = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = '0; lat_fix = 1; lat_rand = 0; salt = '0; last_due = 0;
      exp_tail = '0;

      // Streaming from reset, L=1: pcs 0,1,2,... from cycle 2, one per cycle.
      do_reset(3, 1'b1, 32'd0);
      step(1'b0, '0, 1'b1);
      chk("a_c1_valid", 32'(out_valid), 32'd0);
      for (int k = 2; k < 10; k++) begin
         step(1'b0, '0, 1'b1);
         chk("a_valid", 32'(out_valid), 32'd1);
         chk("a_pc", 32'(out_pc), 32'(k - 2));
      end
      chk("a_opcode", 32'(out_opcode), 32'b00010);
`ifdef FETCH_PERF_CNT_EN
      chk("a_perf_fetched", perf_fetched, 32'd8);
`endif

      // Backpressure: two requests, head frozen at pc 0, then drain in order.
      do_reset(2, 1'b0, 32'd0);
      base = req_count;
      repeat (6) step(1'b0, '0, 1'b0);
      chk("b_req_count", req_count - base, 32'd2);
      chk("b_valid", 32'(out_valid), 32'd1);
      chk("b_head_pc", 32'(out_pc), 32'd0);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, '0, 1'b1);
         chk("b_drain_valid", 32'(out_valid), 32'd1);
         chk("b_drain_pc", 32'(out_pc), 32'(k));
      end

      // Redirect in the cycle pc 3's response arrives; new stream at R+3.
      do_reset(2, 1'b1, 32'd0);
      repeat (3) step(1'b0, '0, 1'b1);
      step(1'b1, AW'(12'h040), 1'b1);
      step(1'b0, '0, 1'b1);
      chk("c_r1_req", 32'(imem_req), 32'd1);
      chk("c_r1_addr", 32'(imem_addr), 32'h040);
      chk("c_r1_valid", 32'(out_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("c_perf_flushed", perf_flushed, 32'd2);
`endif
      step(1'b0, '0, 1'b1);
      chk("c_r2_valid", 32'(out_valid), 32'd0);
      step(1'b0, '0, 1'b1);
      chk("c_r3_valid", 32'(out_valid), 32'd1);
      chk("c_r3_pc", 32'(out_pc), 32'h040);
      repeat (4) step(1'b0, '0, 1'b1);

      // Back-to-back redirects with latency 3: only the 0x200 stream survives.
      lat_fix = 3;
      repeat (10) step(1'b0, '0, 1'b1);
      step(1'b1, AW'(12'h100), 1'b1);
      step(1'b1, AW'(12'h200), 1'b1);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step(1'b0, '0, 1'b1);
         seen = out_valid;
      end
      chk("d_new_stream_seen", 32'(seen), 32'd1);
      chk("d_first_pc", 32'(out_pc), 32'h200);
      repeat (20) step(1'b0, '0, 1'($urandom_range(0, 1)));

      // PC wrap at the top of the address space.
      lat_fix = 1;
      do_reset(2, 1'b1, 32'd0);
      repeat (3) step(1'b0, '0, 1'b1);
      step(1'b1, AW'(12'hFFF), 1'b1);
      repeat (3) step(1'b0, '0, 1'b1);
      chk("e_pc_fff", 32'(out_pc), 32'hFFF);
      chk("e_plus1_wrap", 32'(out_pc_plus1), 32'h000);
      step(1'b0, '0, 1'b1);
      chk("e_pc_000", 32'(out_pc), 32'h000);

      // Randomized traffic with random latency, redirects and one reset.
      lat_rand = 1;
      do_reset(2, 1'b1, $urandom);
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset(1, 1'b1, $urandom);
         else step(($urandom_range(0, 31) == 0), AW'($urandom), ($urandom_range(0, 3) != 0));
      end

      // Reset pulse with two entries buffered clears outputs at once.
      lat_rand = 0;
      lat_fix  = 1;
      do_reset(2, 1'b0, 32'd0);
      repeat (5) step(1'b0, '0, 1'b0);
      chk("g_buffered_valid", 32'(out_valid), 32'd1);
      do_reset(2, 1'b1, 32'd0);
      repeat (4) step(1'b0, '0, 1'b1);
      chk("g_restart_pc", 32'(out_pc), 32'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
